alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin arbiter and
// a single-entry result register with valid/ready handshakes on both sides.
//
// Configuration macro: ALU_ARBITER_FIXED_PRIO_EN
//   undefined (default) -> round-robin arbitration with a last-granted pointer
//   defined             -> fixed priority, req0 wins every tie
//
// Ports (alu_arbiter):
//   clk_i                  clock, all state updates on the rising edge
//   rst_i                  synchronous active-high reset
//   reqK_valid_i           requester K presents an operation
//   reqK_ready_o           requester K operation accepted this cycle
//   reqK_sel_i             3-bit opcode of requester K
//   reqK_a_i, reqK_b_i     N-bit operands of requester K
//   rsp_valid_o            a result is held
//   rsp_ready_i            consumer takes the held result this cycle
//   rsp_id_o               requester that produced the held result
//   rsp_s_o, rsp_z_o       held result and zero flag
//
// Ports (alu_arbiter_alu): sel_i opcode, a_i/b_i operands, s_o result, z_o zero.

module alu_arbiter_alu #(
  parameter int unsigned N = 4
) (
  input  logic [2:0]   sel_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] s_o,
  output logic         z_o
);

  always_comb begin
    s_o = '0;
    z_o = 1'b0;
    case (sel_i)
      3'b000: s_o = a_i + b_i;
      3'b001: begin
        s_o = a_i - b_i;
        z_o = (a_i == b_i);
      end
      3'b010: s_o = a_i & b_i;
      3'b011: s_o = a_i | b_i;
      3'b101: s_o[0] = (a_i < b_i);
      3'b110: s_o = a_i << b_i;
      default: s_o = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [2:0]   req0_sel_i,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [2:0]   req1_sel_i,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [N-1:0] rsp_s_o,
  output logic         rsp_z_o
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   s_q;
  logic           z_q;
  logic           id_q;
  logic           slot_free;
  logic           win_id;
  logic           accept;
  logic [2:0]     op_sel;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N-1:0]   alu_s;
  logic           alu_z;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  // Requester granted on the most recent accepted transfer.
  logic last_q;
`endif

  // Arbitration winner; only meaningful when at least one requester is valid.
  always_comb begin
    win_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      win_id = 1'b0;
`else
      win_id = ~last_q;
`endif
    end else if (req1_valid_i) begin
      win_id = 1'b1;
    end
  end

  assign slot_free    = (state_q == StIdle) || rsp_ready_i;
  assign accept       = slot_free && (req0_valid_i || req1_valid_i) && !rst_i;
  assign req0_ready_o = accept && !win_id;
  assign req1_ready_o = accept && win_id;

  assign op_sel = win_id ? req1_sel_i : req0_sel_i;
  assign op_a   = win_id ? req1_a_i   : req0_a_i;
  assign op_b   = win_id ? req1_b_i   : req0_b_i;

  alu_arbiter_alu #(
    .N (N)
  ) u_alu (
    .sel_i (op_sel),
    .a_i   (op_a),
    .b_i   (op_b),
    .s_o   (alu_s),
    .z_o   (alu_z)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StHold;
      StHold: if (rsp_ready_i && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      s_q     <= '0;
      z_q     <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        s_q  <= alu_s;
        z_q  <= alu_z;
        id_q <= win_id;
      end
    end
  end

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  // Reset to 1 so that req0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= win_id;
    end
  end
`endif

  assign rsp_valid_o = (state_q == StHold);
  assign rsp_s_o     = s_q;
  assign rsp_z_o     = z_q;
  assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level
// reference model (held result slot, last-granted requester, arithmetic ALU).
module tb_alu_arbiter;

  localparam int unsigned N = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, rr;
  logic [2:0]   s0, s1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         rdy0, rdy1, rsp_valid, rsp_id, rsp_z;
  logic [N-1:0] rsp_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit m_held;
  int m_s;
  bit m_z;
  bit m_id;
  bit m_last;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N (N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (v0),
    .req0_ready_o (rdy0),
    .req0_sel_i   (s0),
    .req0_a_i     (a0),
    .req0_b_i     (b0),
    .req1_valid_i (v1),
    .req1_ready_o (rdy1),
    .req1_sel_i   (s1),
    .req1_a_i     (a1),
    .req1_b_i     (b1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rr),
    .rsp_id_o     (rsp_id),
    .rsp_s_o      (rsp_s),
    .rsp_z_o      (rsp_z)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_s(input int sel, input int a, input int b);
    case (sel)
      0: return (a + b) & MASK;
      1: return (a - b) & MASK;
      2: return a & b;
      3: return a | b;
      5: return (a < b) ? 1 : 0;
      6: return (a << b) & MASK;
      default: return 0;
    endcase
  endfunction

  // One clock: drive at negedge, check readies, update model at posedge, check outputs.
  task automatic cycle(input bit r, input bit iv0, input int is0, input int ia0, input int ib0,
                       input bit iv1, input int is1, input int ia1, input int ib1,
                       input bit irr);
    bit free, win, e0, e1;
    int sel, a, b;
    @(negedge clk);
    rst = r; rr = irr;
    v0 = iv0; s0 = 3'(is0); a0 = N'(ia0); b0 = N'(ib0);
    v1 = iv1; s1 = 3'(is1); a1 = N'(ia1); b1 = N'(ib1);
    #1;
    free = !m_held || irr;
    if (iv0 && iv1) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = (m_last == 1'b1) ? 1'b0 : 1'b1;
`endif
    end else begin
      win = iv1;
    end
    e0 = !r && free && iv0 && (win == 1'b0);
    e1 = !r && free && iv1 && (win == 1'b1);
    check_eq("req0_ready", int'(rdy0), int'(e0));
    check_eq("req1_ready", int'(rdy1), int'(e1));
    @(posedge clk);
    #1;
    if (r) begin
      m_held = 0; m_s = 0; m_z = 0; m_id = 0; m_last = 1;
    end else if (e0 || e1) begin
      sel = win ? is1 : is0;
      a   = (win ? ia1 : ia0) & MASK;
      b   = (win ? ib1 : ib0) & MASK;
      m_held = 1;
      m_s    = ref_s(sel, a, b);
      m_z    = (sel == 1) && (a == b);
      m_id   = win;
      m_last = win;
    end else if (m_held && irr) begin
      m_held = 0;
    end
    check_eq("rsp_valid", int'(rsp_valid), int'(m_held));
    check_eq("rsp_s", int'(rsp_s), m_s);
    check_eq("rsp_z", int'(rsp_z), int'(m_z));
    check_eq("rsp_id", int'(rsp_id), int'(m_id));
  endtask

  initial begin
    int exp_id;
    rst = 1; rr = 0; v0 = 0; v1 = 0; s0 = 0; s1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    m_held = 0; m_s = 0; m_z = 0; m_id = 0; m_last = 1;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ADD 3+4 from req0
    cycle(0, 1, 0, 3, 4, 0, 0, 0, 0, 1);
    check_eq("add_valid", int'(rsp_valid), 1);
    check_eq("add_s", int'(rsp_s), 7);
    check_eq("add_z", int'(rsp_z), 0);
    check_eq("add_id", int'(rsp_id), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("add_drop", int'(rsp_valid), 0);

    // SUB 5-5 and SLT 2<9 from req1
    cycle(0, 0, 0, 0, 0, 1, 1, 5, 5, 1);
    check_eq("sub_s", int'(rsp_s), 0);
    check_eq("sub_z", int'(rsp_z), 1);
    check_eq("sub_id", int'(rsp_id), 1);
    cycle(0, 0, 0, 0, 0, 1, 5, 2, 9, 1);
    check_eq("slt_s", int'(rsp_s), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Both valid continuously after reset
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 2, 15, 6, 1, 3, 1, 8, 1);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % 2;
`endif
      check_eq("rr_id", int'(rsp_id), exp_id);
      check_eq("rr_valid", int'(rsp_valid), 1);
    end

    // Held result with consumer stalled for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, 1, 1, 0, 2, 2, 0);
      check_eq("stall_ready", int'(rdy0 | rdy1), 0);
    end
    cycle(0, 1, 6, 1, 2, 0, 0, 0, 0, 1);
    check_eq("resume_s", int'(rsp_s), 4);

    // Reset during HOLD
    cycle(0, 1, 3, 9, 4, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 1, 0, 1, 1, 0);
    check_eq("rst_valid", int'(rsp_valid), 0);
    check_eq("rst_s", int'(rsp_s), 0);
    cycle(0, 1, 0, 1, 1, 1, 0, 2, 2, 1);
    check_eq("rst_tie_id", int'(rsp_id), 0);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 15),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 15),
            ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
